div_clk_monitor: RTL and testbench

Measurement stage downstream of the fixed-ratio clock dividers. It samples a divided clock, for example the divide-by-5 output, as a data signal in the source `clk` domain. It measures period and high time in `clk` cycles, then reports each measurement through a valid/ready interface. It also flags period errors, timeout and lock status for bring-up and built-in checking.

---
 rtl/div_clk_monitor.sv | 149 ++++++++++++++
 tb/tb_div_clk_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Period / high-time monitor for a divided clock sampled as data in the clk domain.
// Optional duty check enabled by defining DIV_MON_DUTY_CHECK_EN.
module div_clk_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 5,
    parameter int EXP_HIGH    = 2,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_err,
    output logic             duty_err,
    output logic             overrun,
    output logic             timeout,
    output logic             lock
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic {SEEK, RUN} state_t;

    state_t                   state, state_next;
    logic [SYNC_STAGES-1:0]   sync_p0;
    logic                     s, s_d, rise;
    logic [CNT_W-1:0]         per_cnt, high_cnt;
    logic [GOOD_W-1:0]        good_cnt;
    logic                     start, capture, tmo_hit, transfer;
    logic                     period_ok, duty_ok, bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // One extra bit keeps the signed difference free of wraparound.
    function automatic logic within_tol(input logic [CNT_W-1:0] val, input int expv);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, val}) - $signed((CNT_W+1)'(expv));
        if (diff < 0) diff = -diff;
        return diff <= $signed((CNT_W+1)'(TOL));
    endfunction

    assign s         = sync_p0[SYNC_STAGES-1];
    assign rise      = s & ~s_d;
    assign transfer  = meas_valid & meas_ready;
    assign period_ok = within_tol(per_cnt, EXP_PERIOD);
`ifdef DIV_MON_DUTY_CHECK_EN
    assign duty_ok   = within_tol(high_cnt, EXP_HIGH);
`else
    assign duty_ok   = 1'b1;
`endif
    assign bad       = ~period_ok | ~duty_ok;
    assign lock      = (good_cnt == GOOD_W'(LOCK_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEEK;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            SEEK: begin
                if (rise) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (per_cnt == CNT_W'(TIMEOUT)) begin
                    tmo_hit    = 1'b1;
                    state_next = SEEK;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    // stage p0: synchroniser and edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            s_d     <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            s_d     <= s;
        end
    end

    // stage p1: counters, capture, status and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt    <= '0;
            high_cnt   <= '0;
            good_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            duty_err   <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            period_err <= capture & ~period_ok;
            duty_err   <= capture & ~duty_ok;

            if (start || capture) begin
                per_cnt  <= CNT_W'(1);
                high_cnt <= CNT_W'(1);
            end else if (state == RUN && !tmo_hit) begin
                per_cnt <= sat_inc(per_cnt);
                if (s) high_cnt <= sat_inc(high_cnt);
            end

            if (capture) begin
                period    <= per_cnt;
                high_time <= high_cnt;
                timeout   <= 1'b0;
                if (bad)       good_cnt <= '0;
                else if (!lock) good_cnt <= good_cnt + 1'b1;
            end else if (tmo_hit) begin
                timeout  <= 1'b1;
                good_cnt <= '0;
            end

            if (capture) begin
                meas_valid <= 1'b1;
                if (meas_valid && !meas_ready) overrun <= 1'b1;
                else if (transfer)             overrun <= 1'b0;
            end else if (transfer) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: rise-time based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_div_clk_monitor;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int EXP_PERIOD  = 5;
    localparam int EXP_HIGH    = 2;
    localparam int TOL         = 1;
    localparam int LOCK_CNT    = 4;
    localparam int TIMEOUT     = 1024;
`ifdef DIV_MON_DUTY_CHECK_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period, high_time;
    logic             period_err, duty_err, overrun, timeout, lock;

    div_clk_monitor #(
        .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .EXP_PERIOD(EXP_PERIOD),
        .EXP_HIGH(EXP_HIGH), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_ready(meas_ready),
        .meas_valid(meas_valid), .period(period), .high_time(high_time),
        .period_err(period_err), .duty_err(duty_err), .overrun(overrun),
        .timeout(timeout), .lock(lock)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: works from the cycle numbers of sampled rising edges.
    bit samp[$];
    int cyc = 0, last_rise = 0, highs = 0, streak = 0;
    bit run = 0, m_valid = 0, m_perr = 0, m_derr = 0, m_ovr = 0, m_tmo = 0;
    int m_period = 0, m_high = 0;

    function automatic bit near(input int v, input int e);
        return (v - e <= TOL) && (e - v <= TOL);
    endfunction

    initial begin : model
        bit s_cur, s_prv, r, xfer;
        int per;
        forever begin
            @(posedge clk);
            if (rst) begin
                samp = {};
                for (int k = 0; k <= SYNC_STAGES; k++) samp.push_back(1'b0);
                cyc = 0; last_rise = 0; highs = 0; streak = 0; run = 0;
                m_valid = 0; m_perr = 0; m_derr = 0; m_ovr = 0; m_tmo = 0;
                m_period = 0; m_high = 0;
            end else begin
                cyc++;
                s_cur = samp[SYNC_STAGES-1];
                s_prv = samp[SYNC_STAGES];
                samp.push_front(sig_in);
                void'(samp.pop_back());
                r    = s_cur && !s_prv;
                xfer = m_valid && meas_ready;
                m_perr = 0;
                m_derr = 0;
                if (run && r) begin
                    per      = cyc - last_rise;
                    m_period = per;
                    m_high   = highs;
                    m_perr   = !near(per, EXP_PERIOD);
                    m_derr   = DUTY_EN && !near(highs, EXP_HIGH);
                    streak   = (m_perr || m_derr) ? 0 : streak + 1;
                    m_tmo    = 0;
                    if (m_valid && !meas_ready) m_ovr = 1;
                    else if (xfer)              m_ovr = 0;
                    m_valid = 1;
                end else if (xfer) begin
                    m_valid = 0;
                    m_ovr   = 0;
                end
                if (r) begin
                    run = 1; last_rise = cyc; highs = 1;
                end else if (run) begin
                    if (cyc - last_rise == TIMEOUT) begin
                        m_tmo = 1; streak = 0; run = 0;
                    end else if (s_cur) begin
                        highs++;
                    end
                end
            end
        end
    end

    int perr_total = 0, derr_total = 0, lock_total = 0, valid_total = 0;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ctrl", {meas_valid, period_err, duty_err, overrun, timeout, lock},
                      {m_valid, m_perr, m_derr, m_ovr, m_tmo, (streak >= LOCK_CNT)});
                check("data", {period, high_time}, {m_period[15:0], m_high[15:0]});
                perr_total  += int'(period_err);
                derr_total  += int'(duty_err);
                lock_total  += int'(lock);
                valid_total += int'(meas_valid);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse(input int p, input int h);
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            sig_in = (i < h);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sig_in = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
    endtask

    initial begin : stim
        int p0, l0, v0, d0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {meas_valid, period, high_time, period_err, duty_err,
                                overrun, timeout, lock}, 0);
        rst = 1'b0;

        // divide-by-5, always ready
        meas_ready = 1'b1;
        p0 = perr_total;
        repeat (4) pulse(5, 2);
        check("s1_period", period, 5);
        check("s1_high", high_time, 2);
        check("s1_no_lock_yet", lock, 0);
        pulse(5, 2);
        check("s1_lock", lock, 1);
        check("s1_no_perr", perr_total - p0, 0);

        // alternating 5 / 8
        do_reset();
        meas_ready = 1'b1;
        p0 = perr_total;
        l0 = lock_total;
        pulse(5, 2);
        repeat (3) begin
            pulse(8, 2);
            pulse(5, 2);
        end
        check("s2_perr_count", perr_total - p0, 3);
        check("s2_never_lock", lock_total - l0, 0);

        // timeout after lock
        do_reset();
        meas_ready = 1'b1;
        repeat (5) pulse(5, 2);
        check("s3_locked", lock, 1);
        repeat (TIMEOUT + 8) @(negedge clk);
        check("s3_timeout", timeout, 1);
        check("s3_unlock", lock, 0);
        pulse(5, 2);
        check("s3_timeout_held", timeout, 1);
        pulse(5, 2);
        check("s3_timeout_cleared", timeout, 0);
        check("s3_period", period, 5);

        // overrun with ready low over two captures
        do_reset();
        meas_ready = 1'b0;
        pulse(5, 2);
        pulse(6, 2);
        check("s4_valid", meas_valid, 1);
        check("s4_hold5", period, 5);
        check("s4_no_overrun", overrun, 0);
        pulse(5, 2);
        check("s4_period6", period, 6);
        check("s4_overrun", overrun, 1);
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        check("s4_drain_valid", meas_valid, 0);
        check("s4_drain_overrun", overrun, 0);

        // ready rises in the capture cycle
        pulse(7, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sig_in = (i < 2);
            if (i == 2) meas_ready = 1'b1;
            if (i == 3) begin
                check("s5_valid", meas_valid, 1);
                check("s5_period", period, 7);
                check("s5_overrun", overrun, 0);
            end
        end

        // reset mid-period
        do_reset();
        meas_ready = 1'b1;
        pulse(5, 2);
        pulse(5, 2);
        @(negedge clk);
        check("s6_pre_reset", period, 5);
        rst = 1'b1;
        #1;
        check("s6_reset_outputs", {meas_valid, period, high_time, period_err, duty_err,
                                   overrun, timeout, lock}, 0);
        @(negedge clk);
        rst = 1'b0;
        v0 = valid_total;
        pulse(5, 2);
        check("s6_no_meas_first_rise", valid_total - v0, 0);
        check("s6_period_zero", period, 0);
        pulse(5, 2);
        check("s6_second_rise", period, 5);

        // duty check with a high time of 4
        do_reset();
        meas_ready = 1'b1;
        d0 = derr_total;
        repeat (5) pulse(5, 2);
        check("s7_locked", lock, 1);
        pulse(5, 4);
        pulse(5, 2);
        check("s7_high", high_time, 4);
        check("s7_duty_err", derr_total - d0, DUTY_EN ? 1 : 0);
        check("s7_lock", lock, DUTY_EN ? 0 : 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
